// File: rtl/io_periph_pkg.sv
// Shared address map and decode constants for the memory-mapped I/O responder.
// The processor-side decode imports the same constants.
package io_periph_pkg;

    localparam logic [15:0] IO_KDATA  = 16'hFFF0;
    localparam logic [15:0] IO_SDATA  = 16'hFFF2;
    localparam logic [15:0] IO_KCTRL  = 16'hFFF4;
    localparam logic [15:0] IO_UNUSED = 16'hFFF6;
    localparam logic [15:0] IO_HEX    = 16'hFFF8;
    localparam logic [15:0] IO_LEDR   = 16'hFFFA;
    localparam logic [15:0] IO_LEDG   = 16'hFFFC;
    localparam logic [15:0] IO_TIMER  = 16'hFFFE;

    localparam logic [15:0] IO_FILL   = 16'hDEAD;
    localparam logic [11:0] IO_PREFIX = 12'hFFF;

    // Register index is the halfword offset inside the 16-byte window.
    typedef enum logic [2:0] {
        REG_KDATA  = IO_KDATA[3:1],
        REG_SDATA  = IO_SDATA[3:1],
        REG_KCTRL  = IO_KCTRL[3:1],
        REG_UNUSED = IO_UNUSED[3:1],
        REG_HEX    = IO_HEX[3:1],
        REG_LEDR   = IO_LEDR[3:1],
        REG_LEDG   = IO_LEDG[3:1],
        REG_TIMER  = IO_TIMER[3:1]
    } io_reg_e;

    function automatic logic io_sel(input logic [15:0] addr);
        return (addr[15:4] == IO_PREFIX);
    endfunction

    function automatic io_reg_e io_reg_of(input logic [15:0] addr);
        return io_reg_e'(addr[3:1]);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-bit two-flop synchronizer followed by a stability-counting debouncer.
// A bit's clean value changes only after CYCLES consecutive differing samples.
module io_debounce
    import io_periph_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] RAW,
    input  logic [WIDTH-1:0] RST_VAL,
    output logic [WIDTH-1:0] CLEAN
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] clean_r;
    logic [CW-1:0]    cnt_r [WIDTH];

    // Synchronizer chain and per-bit debounce counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_r <= RST_VAL;
            sync2_r <= RST_VAL;
            clean_r <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_r <= RAW;
            sync2_r <= sync1_r;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_r[i] == clean_r[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                end else if (cnt_r[i] == CNT_LAST) begin
                    clean_r[i] <= sync2_r[i];
                    cnt_r[i]   <= {CW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    assign CLEAN = clean_r;

endmodule

// File: rtl/io_periph.sv
// Memory-mapped I/O responder: debounced keys/switches, key-press latches,
// HEX/LED output registers, a millisecond timer and the read-data mux.
module io_periph
    import io_periph_pkg::*;
#(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int TICK_CYCLES     = 50000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic             WE,
    input  logic [DBITS-1:0] DIN,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEX,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic [3:0]    key_db_s;
    logic [9:0]    sw_db_s;
    logic          sel_s;
    io_reg_e       reg_s;
    logic          wr_s;
    logic [3:0]    press_ev_s;
    logic [3:0]    clr_press_s;
    logic [3:0]    clr_ovr_s;
    logic          tick_s;
    logic [15:0]   dout_s;
    logic          unused_s;

    logic [3:0]    key_prev_r;
    logic [3:0]    press_r;
    logic [3:0]    ovr_r;
    logic [15:0]   hex_r;
    logic [9:0]    ledr_r;
    logic [7:0]    ledg_r;
    logic [15:0]   timer_r;
    logic [PW-1:0] presc_r;

    // Buttons idle high, so their debounced reset value is all ones.
    io_debounce #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .CLK     (CLK),
        .RESET   (RESET),
        .RAW     (KEY),
        .RST_VAL (4'hF),
        .CLEAN   (key_db_s)
    );

    io_debounce #(.WIDTH(10), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .CLK     (CLK),
        .RESET   (RESET),
        .RAW     (SW),
        .RST_VAL (10'h000),
        .CLEAN   (sw_db_s)
    );

    assign unused_s = ADDR[0];

    // Address decode, press-event detection, W1C masks and timer tick.
    always_comb begin
        sel_s       = io_sel(ADDR[15:0]);
        reg_s       = io_reg_of(ADDR[15:0]);
        wr_s        = WE & sel_s;
        press_ev_s  = key_prev_r & ~key_db_s;
        clr_press_s = 4'h0;
        clr_ovr_s   = 4'h0;
        if (wr_s && (reg_s == REG_KCTRL)) begin
            clr_press_s = DIN[3:0];
            clr_ovr_s   = DIN[7:4];
        end else begin
            clr_press_s = 4'h0;
            clr_ovr_s   = 4'h0;
        end
        tick_s = (presc_r == PRESC_LAST);
    end

    // Press/overrun latches; an event on a bit being cleared re-arms PRESS only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_prev_r <= 4'hF;
            press_r    <= 4'h0;
            ovr_r      <= 4'h0;
        end else begin
            key_prev_r <= key_db_s;
            press_r    <= (press_r & ~clr_press_s) | press_ev_s;
            ovr_r      <= (ovr_r & ~clr_ovr_s) | (press_ev_s & press_r & ~clr_press_s);
        end
    end

    // Processor-writable output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hex_r  <= 16'h0000;
            ledr_r <= 10'h000;
            ledg_r <= 8'h00;
        end else if (wr_s) begin
            case (reg_s)
                REG_HEX:  hex_r  <= DIN[15:0];
                REG_LEDR: ledr_r <= DIN[9:0];
                REG_LEDG: ledg_r <= DIN[7:0];
                default:  ;
            endcase
        end
    end

    // Prescaler runs freely; a timer write beats a coincident tick.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_r <= {PW{1'b0}};
            timer_r <= 16'h0000;
        end else begin
            presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
            if (wr_s && (reg_s == REG_TIMER)) begin
                timer_r <= DIN[15:0];
            end else if (tick_s) begin
                timer_r <= timer_r + 16'd1;
            end
        end
    end

    // Read-data mux.
    always_comb begin
        dout_s = IO_FILL;
        if (sel_s) begin
            case (reg_s)
                REG_KDATA: dout_s = {12'h000, key_db_s};
                REG_SDATA: dout_s = {6'b000000, sw_db_s};
                REG_KCTRL: dout_s = {8'h00, ovr_r, press_r};
                REG_HEX:   dout_s = hex_r;
                REG_LEDR:  dout_s = {6'b000000, ledr_r};
                REG_LEDG:  dout_s = {8'h00, ledg_r};
                REG_TIMER: dout_s = timer_r;
                default:   dout_s = IO_FILL;
            endcase
        end else begin
            dout_s = IO_FILL;
        end
    end

    assign DOUT = DBITS'(dout_s);
    assign SEL  = sel_s;
    assign HEX  = hex_r;
    assign LEDR = ledr_r;
    assign LEDG = ledg_r;

endmodule

// File: tb/tb_io_periph.sv
// Directed bench for io_periph with short debounce (4) and tick (10) periods.
`timescale 1ns/1ps
module tb_io_periph;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ADDR;
    logic        WE;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        SEL;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] HEX;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int total = 0;
    int bad   = 0;

    io_periph #(.DBITS(16), .DEBOUNCE_CYCLES(4), .TICK_CYCLES(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ADDR  (ADDR),
        .WE    (WE),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .SEL   (SEL),
        .KEY   (KEY),
        .SW    (SW),
        .HEX   (HEX),
        .LEDR  (LEDR),
        .LEDG  (LEDG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] exp);
        ADDR = a;
        #0.1;
        check(tag, DOUT, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DIN  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        ADDR  = 16'h0000;
        WE    = 1'b0;
        DIN   = 16'h0000;
        KEY   = 4'hF;
        SW    = 10'h000;
        steps(2);
        RESET = 1'b0;

        // Reset state and decode
        rd(16'hFFF0, "rst_kdata", 16'h000F);
        rd(16'hFFF2, "rst_sdata", 16'h0000);
        rd(16'hFFF4, "rst_kctrl", 16'h0000);
        rd(16'hFFF8, "rst_hex",   16'h0000);
        rd(16'hFFFA, "rst_ledr",  16'h0000);
        rd(16'hFFFC, "rst_ledg",  16'h0000);
        rd(16'hFFFE, "rst_timer", 16'h0000);
        rd(16'hFFF6, "unused_rd", 16'hDEAD);
        rd(16'h1000, "nosel_rd",  16'hDEAD);
        check("nosel_sel", {15'h0000, SEL}, 16'h0000);
        ADDR = 16'hFFF1;
        #0.1;
        check("sel_odd", {15'h0000, SEL}, 16'h0001);

        // Debounce latency and press event
        KEY = 4'hD;
        steps(5);
        rd(16'hFFF0, "kdata_early", 16'h000F);
        step();
        rd(16'hFFF0, "kdata_lat6", 16'h000D);
        step();
        rd(16'hFFF4, "kctrl_press1", 16'h0002);
        KEY = 4'hF;
        steps(8);
        rd(16'hFFF0, "kdata_release", 16'h000F);
        rd(16'hFFF4, "kctrl_no_rel_ev", 16'h0002);
        KEY = 4'hD;
        steps(3);
        KEY = 4'hF;
        steps(8);
        rd(16'hFFF0, "kdata_glitch", 16'h000F);
        rd(16'hFFF4, "kctrl_glitch", 16'h0002);
        wr(16'hFFF4, 16'h000F);
        rd(16'hFFF4, "kctrl_clear_all", 16'h0000);

        SW = 10'h2A5;
        steps(5);
        rd(16'hFFF2, "sdata_early", 16'h0000);
        step();
        rd(16'hFFF2, "sdata_lat6", 16'h02A5);

        // Overrun and W1C
        KEY = 4'hB;
        steps(8);
        rd(16'hFFF4, "kctrl_k2_once", 16'h0004);
        KEY = 4'hF;
        steps(8);
        KEY = 4'hB;
        steps(8);
        rd(16'hFFF4, "kctrl_k2_twice", 16'h0044);
        wr(16'hFFF4, 16'h0004);
        rd(16'hFFF4, "w1c_press", 16'h0040);
        wr(16'hFFF4, 16'h0040);
        rd(16'hFFF4, "w1c_ovr", 16'h0000);
        KEY = 4'hF;
        steps(8);
        KEY = 4'hB;
        steps(8);
        KEY = 4'hF;
        steps(8);
        rd(16'hFFF4, "kctrl_rearm", 16'h0004);
        KEY = 4'hB;
        steps(6);
        wr(16'hFFF4, 16'h00FF);
        rd(16'hFFF4, "clr_same_cycle", 16'h0004);
        rd(16'hFFF0, "kdata_b", 16'h000B);

        // Output registers
        wr(16'hFFF8, 16'hBEEF);
        wr(16'hFFFA, 16'hFFFF);
        wr(16'hFFFC, 16'h0155);
        check("hex_port",  HEX, 16'hBEEF);
        check("ledr_port", {6'b000000, LEDR}, 16'h03FF);
        check("ledg_port", {8'h00, LEDG}, 16'h0055);
        rd(16'hFFF8, "hex_rb",  16'hBEEF);
        rd(16'hFFFA, "ledr_rb", 16'h03FF);
        rd(16'hFFFC, "ledg_rb", 16'h0055);
        wr(16'hFFF0, 16'h0000);
        rd(16'hFFF0, "kdata_ro", 16'h000B);
        wr(16'h1008, 16'h0000);
        check("hex_nosel_wr", HEX, 16'hBEEF);
        KEY = 4'hF;
        steps(8);

        // Timer
        do_reset();
        steps(29);
        rd(16'hFFFE, "timer_29", 16'h0002);
        step();
        rd(16'hFFFE, "timer_30", 16'h0003);
        wr(16'hFFFE, 16'hFFFF);
        rd(16'hFFFE, "timer_load", 16'hFFFF);
        steps(8);
        rd(16'hFFFE, "timer_pre_wrap", 16'hFFFF);
        step();
        rd(16'hFFFE, "timer_wrap", 16'h0000);
        steps(9);
        wr(16'hFFFE, 16'h1234);
        rd(16'hFFFE, "timer_wr_on_tick", 16'h1234);
        steps(10);
        rd(16'hFFFE, "timer_presc_kept", 16'h1235);

        // Reset mid-debounce, overriding a same-cycle write
        wr(16'hFFF8, 16'h1234);
        wr(16'hFFFA, 16'h000F);
        check("hex_pre_rst", HEX, 16'h1234);
        KEY = 4'hE;
        steps(3);
        ADDR  = 16'hFFF8;
        DIN   = 16'hFFFF;
        WE    = 1'b1;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        WE    = 1'b0;
        check("hex_rst_port", HEX, 16'h0000);
        rd(16'hFFF8, "hex_rst",   16'h0000);
        rd(16'hFFFA, "ledr_rst",  16'h0000);
        rd(16'hFFF4, "kctrl_rst", 16'h0000);
        rd(16'hFFFE, "timer_rst", 16'h0000);
        rd(16'hFFF0, "kdata_rst", 16'h000F);
        steps(5);
        rd(16'hFFF0, "kdata_rst_early", 16'h000F);
        step();
        rd(16'hFFF0, "kdata_rst_lat6", 16'h000E);
        step();
        rd(16'hFFF4, "kctrl_after_rst", 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
